// File: rtl/acq_capture_sched_if.sv
// Signal bundle between the capture sequencer and its FIFO, SPRAM bank and host port.
// The master modport is the sequencer; the slave modport is the surrounding fabric.
interface acq_capture_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_AW    = 14
);
  localparam int TOTAL_AW = BANK_AW + $clog2(NUM_BANKS);

  // capture control
  logic                  start;
  logic                  abort;
  logic [TOTAL_AW:0]     n_samples;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  // sample FIFO side
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd_en;
  logic                  fifo_wr_gate;
  logic                  fifo_reset;

  // SPRAM bank side
  logic [NUM_BANKS-1:0]  spram_ce;
  logic [BANK_AW-1:0]    spram_addr;
  logic [DATA_WIDTH-1:0] spram_wdata;
  logic                  spram_wre;

  // host readout side
  logic                  host_rd_req;
  logic [TOTAL_AW-1:0]   host_rd_addr;
  logic                  host_rd_ack;

  modport master (
    input  start, abort, n_samples, fifo_empty, fifo_full, fifo_data,
           host_rd_req, host_rd_addr,
    output busy, done, overflow, fifo_rd_en, fifo_wr_gate, fifo_reset,
           spram_ce, spram_addr, spram_wdata, spram_wre, host_rd_ack
  );

  modport slave (
    output start, abort, n_samples, fifo_empty, fifo_full, fifo_data,
           host_rd_req, host_rd_addr,
    input  busy, done, overflow, fifo_rd_en, fifo_wr_gate, fifo_reset,
           spram_ce, spram_addr, spram_wdata, spram_wre, host_rd_ack
  );
endinterface

// File: rtl/acq_capture_sched.sv
// Capture sequencer: flushes the ADC sample FIFO, drains a requested number of
// samples into consecutive words of a banked SPRAM, and lends the SPRAM to a host
// readout port whenever no capture is running. Every output is a register.
module acq_capture_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_AW    = 14
) (
  input  logic                clk,
  input  logic                reset,
  acq_capture_sched_if.master bus
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int TOTAL_AW  = BANK_AW + BANK_BITS;
  localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam logic [TOTAL_AW:0] CAPACITY = {1'b1, {TOTAL_AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_CAPTURE,
    S_LAST,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic [TOTAL_AW:0]     target_q, target_d;
  logic [TOTAL_AW:0]     rd_cnt_q, rd_cnt_d;
  logic [TOTAL_AW:0]     wr_cnt_q, wr_cnt_d;
  logic                  pend_q, pend_d;          // FIFO data_out is valid this cycle
  logic                  host_iss_q, host_iss_d;  // host access is on the SPRAM pins

  logic                  fifo_rd_en_q, fifo_rd_en_d;
  logic                  fifo_wr_gate_q, fifo_wr_gate_d;
  logic                  fifo_reset_q, fifo_reset_d;
  logic [NUM_BANKS-1:0]  spram_ce_q, spram_ce_d;
  logic [BANK_AW-1:0]    spram_addr_q, spram_addr_d;
  logic [DATA_WIDTH-1:0] spram_wdata_q, spram_wdata_d;
  logic                  spram_wre_q, spram_wre_d;
  logic                  host_rd_ack_q, host_rd_ack_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic [BSEL_W-1:0]     wr_bank;
  logic [BSEL_W-1:0]     host_bank;

  // With a single bank there are no bank-select bits in the linear address.
  generate
    if (BANK_BITS > 0) begin : g_multi_bank
      assign wr_bank   = wr_cnt_q[TOTAL_AW-1:BANK_AW];
      assign host_bank = bus.host_rd_addr[TOTAL_AW-1:BANK_AW];
    end else begin : g_single_bank
      assign wr_bank   = '0;
      assign host_bank = '0;
    end
  endgenerate

  // Next-state and next-output logic; outputs are derived for the state being entered.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    target_d       = target_q;
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    pend_d         = fifo_rd_en_q;
    host_iss_d     = 1'b0;
    overflow_d     = overflow_q;
    fifo_rd_en_d   = 1'b0;
    spram_ce_d     = '0;
    spram_addr_d   = '0;
    spram_wdata_d  = '0;
    spram_wre_d    = 1'b0;
    host_rd_ack_d  = host_iss_q;

    // FIFO data requested last cycle is on data_out now: commit it to the next word.
    if (pend_q) begin
      spram_wre_d   = 1'b1;
      spram_wdata_d = bus.fifo_data;
      spram_ce_d    = NUM_BANKS'(1) << wr_bank;
      spram_addr_d  = wr_cnt_q[BANK_AW-1:0];
      wr_cnt_d      = wr_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d     = S_FLUSH;
          flush_cnt_d = '0;
          rd_cnt_d    = '0;
          wr_cnt_d    = '0;
          overflow_d  = 1'b0;
          if (bus.n_samples == '0 || bus.n_samples > CAPACITY) begin
            target_d = CAPACITY;
          end else begin
            target_d = bus.n_samples;
          end
        end else if (bus.host_rd_req) begin
          host_iss_d   = 1'b1;
          spram_ce_d   = NUM_BANKS'(1) << host_bank;
          spram_addr_d = bus.host_rd_addr[BANK_AW-1:0];
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == 2'd2) begin
          state_d = S_CAPTURE;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      S_CAPTURE: begin
        if (bus.fifo_full) begin
          overflow_d = 1'b1;
        end
        // Skip a cycle after each read: the empty flag lags the read by one cycle.
        if (!bus.fifo_empty && !fifo_rd_en_q && (rd_cnt_q < target_q)) begin
          fifo_rd_en_d = 1'b1;
          rd_cnt_d     = rd_cnt_q + 1'b1;
          if (rd_cnt_q + 1'b1 == target_q) begin
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        if (!fifo_rd_en_q && !pend_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel drops any in-flight read or write and returns to idle.
    if (bus.abort && (state_q == S_FLUSH || state_q == S_CAPTURE || state_q == S_LAST)) begin
      state_d       = S_IDLE;
      fifo_rd_en_d  = 1'b0;
      pend_d        = 1'b0;
      rd_cnt_d      = rd_cnt_q;
      wr_cnt_d      = wr_cnt_q;
      overflow_d    = overflow_q;
      spram_ce_d    = '0;
      spram_addr_d  = '0;
      spram_wdata_d = '0;
      spram_wre_d   = 1'b0;
    end

    fifo_reset_d   = (state_d == S_FLUSH) && (flush_cnt_d == 2'd0);
    fifo_wr_gate_d = (state_d == S_CAPTURE) && (rd_cnt_d < target_d);
    busy_d         = (state_d == S_FLUSH) || (state_d == S_CAPTURE) || (state_d == S_LAST);
    done_d         = (state_d == S_DONE);
  end

  // State and output registers; reset holds the FIFO in reset and everything else at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      flush_cnt_q    <= '0;
      target_q       <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      pend_q         <= 1'b0;
      host_iss_q     <= 1'b0;
      fifo_rd_en_q   <= 1'b0;
      fifo_wr_gate_q <= 1'b0;
      fifo_reset_q   <= 1'b1;
      spram_ce_q     <= '0;
      spram_addr_q   <= '0;
      spram_wdata_q  <= '0;
      spram_wre_q    <= 1'b0;
      host_rd_ack_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      target_q       <= target_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      pend_q         <= pend_d;
      host_iss_q     <= host_iss_d;
      fifo_rd_en_q   <= fifo_rd_en_d;
      fifo_wr_gate_q <= fifo_wr_gate_d;
      fifo_reset_q   <= fifo_reset_d;
      spram_ce_q     <= spram_ce_d;
      spram_addr_q   <= spram_addr_d;
      spram_wdata_q  <= spram_wdata_d;
      spram_wre_q    <= spram_wre_d;
      host_rd_ack_q  <= host_rd_ack_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      overflow_q     <= overflow_d;
    end
  end

  assign bus.fifo_rd_en   = fifo_rd_en_q;
  assign bus.fifo_wr_gate = fifo_wr_gate_q;
  assign bus.fifo_reset   = fifo_reset_q;
  assign bus.spram_ce     = spram_ce_q;
  assign bus.spram_addr   = spram_addr_q;
  assign bus.spram_wdata  = spram_wdata_q;
  assign bus.spram_wre    = spram_wre_q;
  assign bus.host_rd_ack  = host_rd_ack_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_acq_capture_sched.sv
// Bench for acq_capture_sched: behavioural FIFO model, randomized captures and
// host reads, scoreboard queues of expected SPRAM writes and host accesses.
module tb_acq_capture_sched;
  localparam int DW         = 16;
  localparam int NB         = 2;
  localparam int BAW        = 4;
  localparam int TAW        = 5;
  localparam int CAP        = 32;
  localparam int BANK_WORDS = 16;
  localparam int FIFO_DEPTH = 128;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acq_capture_sched_if #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_AW(BAW)) bus ();

  acq_capture_sched #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_AW(BAW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NB-1:0]  ce;
    logic [BAW-1:0] addr;
    logic [DW-1:0]  data;
  } wr_t;
  typedef struct packed {
    logic [NB-1:0]  ce;
    logic [BAW-1:0] addr;
  } host_t;

  wr_t   exp_wr_q[$];
  host_t exp_host_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural sample FIFO (registered data and flags) ----------
  logic [DW-1:0] fq[$];
  logic [DW-1:0] cap_seed = '0;
  int unsigned   wr_k = 0;
  logic          adc_strobe = 1'b0;
  logic          force_full = 1'b0;
  logic          ffull_q = 1'b0;

  assign bus.fifo_full = ffull_q | force_full;

  always @(posedge clk) begin
    if (bus.fifo_reset) begin
      fq.delete();
      wr_k = 0;
    end else begin
      if (bus.fifo_rd_en && fq.size() > 0) bus.fifo_data <= fq.pop_front();
      if (bus.fifo_wr_gate && adc_strobe && fq.size() < FIFO_DEPTH) begin
        fq.push_back(DW'(cap_seed + wr_k));
        wr_k++;
      end
    end
    bus.fifo_empty <= (fq.size() == 0);
    ffull_q        <= (fq.size() >= FIFO_DEPTH);
  end

  // ---------------- monitor: pops the scoreboard whenever the DUT acts ----------
  bit    mon_en = 0;
  bit    gap_check = 0;
  int    cyc = 0;
  int    last_wr_cyc = -1;
  int    rd_pulses = 0;
  logic  prev_host = 1'b0;
  logic  prev_rd = 1'b0;
  wr_t   mon_w;
  host_t mon_h;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (bus.spram_wre) begin
        if (exp_wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got ce=%b addr=%0d data=0x%h, expected no write", bus.spram_ce, bus.spram_addr, bus.spram_wdata);
        end else begin
          mon_w = exp_wr_q.pop_front();
          $display("write ce=%b addr=%0d data=0x%h", bus.spram_ce, bus.spram_addr, bus.spram_wdata);
          chk("wr_ce", 32'(bus.spram_ce), 32'(mon_w.ce));
          chk("wr_addr", 32'(bus.spram_addr), 32'(mon_w.addr));
          chk("wr_data", 32'(bus.spram_wdata), 32'(mon_w.data));
        end
        if (gap_check && last_wr_cyc >= 0) chk("wr_gap", 32'(cyc - last_wr_cyc), 32'd2);
        last_wr_cyc = cyc;
      end else if (bus.spram_ce != '0) begin
        if (exp_host_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_host_access: got ce=%b addr=%0d, expected no access", bus.spram_ce, bus.spram_addr);
        end else begin
          mon_h = exp_host_q.pop_front();
          $display("host read ce=%b addr=%0d", bus.spram_ce, bus.spram_addr);
          chk("host_ce", 32'(bus.spram_ce), 32'(mon_h.ce));
          chk("host_addr", 32'(bus.spram_addr), 32'(mon_h.addr));
        end
      end
      if (bus.host_rd_ack || prev_host) chk("host_ack", 32'(bus.host_rd_ack), 32'(prev_host));
      if (bus.fifo_rd_en) begin
        chk("rd_spacing", 32'(prev_rd), 32'd0);
        chk("rd_nonempty", 32'(fq.size() > 0), 32'd1);
        rd_pulses++;
      end
      if (!bus.busy) last_wr_cyc = -1;
    end
    prev_host = mon_en && !bus.spram_wre && (bus.spram_ce != '0);
    prev_rd   = bus.fifo_rd_en;
  end

  // ---------------- stimulus helpers ----------------
  task automatic host_reads(input int cnt, input logic [TAW-1:0] first_addr, input bit use_first);
    for (int i = 0; i < cnt; i++) begin
      host_t h;
      logic [TAW-1:0] a;
      a = (i == 0 && use_first) ? first_addr : TAW'($urandom);
      h.ce   = NB'(1) << (int'(a) / BANK_WORDS);
      h.addr = BAW'(int'(a) % BANK_WORDS);
      exp_host_q.push_back(h);
      bus.host_rd_req  = 1'b1;
      bus.host_rd_addr = a;
      step();
    end
    bus.host_rd_req  = 1'b0;
    bus.host_rd_addr = TAW'($urandom);
    step();
    step();
    chk("host_queue_drained", 32'(exp_host_q.size()), 32'd0);
  endtask

  task automatic run_capture(input logic [TAW:0] n, input int abort_after, input int strobe_pct,
                             input bit ovf_pulse, input bit host_with_start, input bit noise);
    int tgt, nexp, base_rd, k;
    bit seen_done, pulse_now, pulsed;
    tgt  = (n == 0 || int'(n) > CAP) ? CAP : int'(n);
    cap_seed = DW'($urandom);
    nexp = (abort_after > 0) ? abort_after - 1 : tgt;
    for (int i = 0; i < nexp; i++) begin
      wr_t e;
      e.ce   = NB'(1) << (i / BANK_WORDS);
      e.addr = BAW'(i % BANK_WORDS);
      e.data = DW'(cap_seed + i);
      exp_wr_q.push_back(e);
    end
    $display("capture n=%0d target=%0d abort_after=%0d strobe=%0d%%", n, tgt, abort_after, strobe_pct);
    base_rd = rd_pulses;
    bus.n_samples    = n;
    bus.start        = 1'b1;
    bus.host_rd_req  = host_with_start;
    bus.host_rd_addr = TAW'($urandom);
    step();
    bus.start       = 1'b0;
    bus.host_rd_req = 1'b0;
    bus.n_samples   = (TAW+1)'($urandom);
    chk("flush1_fifo_reset", 32'(bus.fifo_reset), 32'd1);
    chk("flush1_busy", 32'(bus.busy), 32'd1);
    chk("flush1_done", 32'(bus.done), 32'd0);
    chk("flush1_overflow_clear", 32'(bus.overflow), 32'd0);
    step();
    chk("flush2_fifo_reset", 32'(bus.fifo_reset), 32'd0);
    chk("flush2_gate", 32'(bus.fifo_wr_gate), 32'd0);
    step();
    chk("flush3_gate", 32'(bus.fifo_wr_gate), 32'd0);
    step();
    chk("capture_gate_open", 32'(bus.fifo_wr_gate), 32'd1);
    k = 0;
    seen_done = 0;
    pulse_now = 0;
    pulsed = 0;
    for (int c = 0; c < 3000; c++) begin
      adc_strobe = ($urandom_range(99) < strobe_pct);
      force_full = pulse_now;
      pulse_now  = 0;
      if (noise) begin
        bus.host_rd_req  = ($urandom_range(3) == 0);
        bus.host_rd_addr = TAW'($urandom);
        bus.start        = ($urandom_range(7) == 0);
      end
      step();
      force_full = 1'b0;
      if (bus.fifo_rd_en) k++;
      if (k >= tgt && abort_after == 0) chk("gate_closed_after_last_read", 32'(bus.fifo_wr_gate), 32'd0);
      if (ovf_pulse && !pulsed && bus.spram_wre) begin
        pulse_now = 1;
        pulsed = 1;
      end
      if (abort_after > 0 && k == abort_after) begin
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_gate", 32'(bus.fifo_wr_gate), 32'd0);
        chk("abort_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("abort_wre", 32'(bus.spram_wre), 32'd0);
        step();
        step();
        chk("abort_write_queue", 32'(exp_wr_q.size()), 32'd0);
        seen_done = 1;
        break;
      end
      if (bus.done) begin
        seen_done = 1;
        break;
      end
    end
    bus.host_rd_req = 1'b0;
    bus.start       = 1'b0;
    adc_strobe      = 1'b0;
    if (!seen_done) begin
      vectors++;
      miscompares++;
      $display("FAIL capture_timeout: got no done after 3000 cycles, expected done");
      exp_wr_q.delete();
    end else if (abort_after == 0) begin
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_gate", 32'(bus.fifo_wr_gate), 32'd0);
      chk("done_overflow", 32'(bus.overflow), 32'(ovf_pulse));
      chk("read_count", 32'(rd_pulses - base_rd), 32'(tgt));
      chk("write_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.n_samples    = '0;
    bus.host_rd_req  = 1'b0;
    bus.host_rd_addr = '0;

    // reset held with start asserted: FIFO reset only
    reset     = 1'b0;
    bus.start = 1'b1;
    repeat (3) begin
      step();
      chk("reset_fifo_reset", 32'(bus.fifo_reset), 32'd1);
      chk("reset_outputs", 32'({bus.fifo_rd_en, bus.fifo_wr_gate, bus.spram_ce, bus.spram_addr,
                                bus.spram_wdata, bus.spram_wre, bus.host_rd_ack, bus.busy,
                                bus.done, bus.overflow}), 32'd0);
    end
    reset     = 1'b1;
    bus.start = 1'b0;
    step();
    chk("idle_after_reset_busy", 32'(bus.busy), 32'd0);
    chk("idle_after_reset_fifo_reset", 32'(bus.fifo_reset), 32'd0);
    mon_en = 1;

    // normal capture and bank crossing at full ADC rate
    gap_check = 1;
    run_capture(6'd10, 0, 100, 0, 0, 0);
    run_capture(6'd20, 0, 100, 0, 0, 0);
    gap_check = 0;

    // host reads in DONE, including the cross-bank address
    host_reads(4, 5'h11, 1);

    // abort ignored in DONE
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_in_done_ignored", 32'(bus.done), 32'd1);

    // clamp to capacity with a forced full flag
    run_capture(6'd0, 0, 100, 1, 0, 0);

    // abort after the fifth read, then serve the host from IDLE
    run_capture(6'd12, 5, 100, 0, 0, 0);
    host_reads(2, 5'h00, 0);

    // randomized captures with host noise and stray starts while busy
    for (int it = 0; it < 6; it++) begin
      run_capture((TAW+1)'($urandom_range(0, 40)), 0, $urandom_range(30, 100), 0,
                  bit'($urandom_range(1)), 1);
      host_reads($urandom_range(1, 4), 5'h00, 0);
    end

    step();
    chk("final_write_queue", 32'(exp_wr_q.size()), 32'd0);
    chk("final_host_queue", 32'(exp_host_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
